// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, blank pattern and active-low 7-segment table.
package bcd_pkg;
    typedef logic [3:0] bcd_digit_t;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    function automatic logic [6:0] seg_of(input bcd_digit_t d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction
endpackage

// File: rtl/bcd_decade.sv
// bcd_decade: one BCD digit register with load and ripple-gated up/down step.
module bcd_decade
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_syn,
    input  logic       load,
    input  logic       step,
    input  logic       up,
    input  logic       step_in,
    input  bcd_digit_t din,
    output bcd_digit_t q,
    output logic       at_lim
);
    bcd_digit_t r_q;
    assign q      = r_q;
    assign at_lim = up ? (r_q == 4'd9) : (r_q == 4'd0);
    always_ff @(posedge clk or negedge rst_syn)
        if (!rst_syn)
            r_q <= '0;
        else if (load)
            r_q <= (din > 4'd9) ? 4'd0 : din;
        else if (step && step_in)
            r_q <= up ? ((r_q == 4'd9) ? 4'd0 : r_q + 4'd1)
                      : ((r_q == 4'd0) ? 4'd9 : r_q - 4'd1);
endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: DIGITS-decade up/down BCD counter with scanned common-anode 7-segment output.
module bcd_scan_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 16,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst_syn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  en,
    input  logic                  up,
    input  logic [DIGITS-1:0]     dp,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW = $clog2(SCAN_DIV);
    logic [DIGITS-1:0] w_lim;
    logic [DIGITS-1:0] w_in;
    logic [DIGITS-1:0] w_lz;
    logic [IW-1:0]     r_idx;
    logic [DW-1:0]     r_div;
    logic              r_carry;
    logic [7:0]        r_seg;
    logic [DIGITS-1:0] r_an;
    logic              w_last;
    bcd_digit_t        w_dig;
    logic              w_blank;
    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_dec
            // w_lz[i]: this digit and every higher one are zero
            assign w_lz[i] = (count[4*DIGITS-1:4*i] == '0);
            if (i == 0) begin : g_first
                assign w_in[i] = 1'b1;
            end else begin : g_rest
                assign w_in[i] = &w_lim[i-1:0];
            end
            bcd_decade u_dec (
                .clk     (clk),
                .rst_syn (rst_syn),
                .load    (load),
                .step    (en),
                .up      (up),
                .step_in (w_in[i]),
                .din     (din[4*i +: 4]),
                .q       (count[4*i +: 4]),
                .at_lim  (w_lim[i])
            );
        end
    endgenerate
    always_comb begin
        w_last  = (r_div == DW'(SCAN_DIV - 1));
        w_dig   = count[r_idx*4 +: 4];
        w_blank = (BLANK_LZ != 0) && (r_idx != '0) && w_lz[r_idx];
    end
    always_ff @(posedge clk or negedge rst_syn)
        if (!rst_syn) begin
            r_div   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_seg   <= SEG_BLANK;
            r_an    <= '1;
        end else begin
            r_div   <= w_last ? '0 : r_div + 1'b1;
            r_idx   <= !w_last ? r_idx : (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            r_carry <= !load && en && (&w_lim);
            r_seg   <= {~dp[r_idx], w_blank ? 7'h7F : seg_of(w_dig)};
            r_an    <= ~(DIGITS'(1) << r_idx);
        end
    assign carry = r_carry;
    assign seg   = r_seg;
    assign an    = r_an;
endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: directed and random stimulus checked against an integer-valued display model.
module tb_bcd_scan_counter;
    localparam int D  = 4;
    localparam int SD = 2;
    localparam logic [6:0] SEGT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic        clk = 1'b0;
    logic        rst_syn = 1'b0;
    logic        load = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic [15:0] din = '0;
    logic [3:0]  dp = '0;
    logic [15:0] count;
    logic        carry;
    logic [7:0]  seg;
    logic [3:0]  an;
    int checks = 0;
    int errors = 0;
    int m_val = 0;
    int m_t = 0;
    logic       m_carry = 1'b0;
    logic [7:0] m_seg = 8'hFF;
    logic [3:0] m_an = 4'hF;

    always #5 clk = ~clk;

    bcd_scan_counter #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_LZ(1)) dut (
        .clk(clk), .rst_syn(rst_syn), .load(load), .din(din), .en(en), .up(up),
        .dp(dp), .count(count), .carry(carry), .seg(seg), .an(an)
    );

    function automatic int p10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int k = 0; k < D; k++) r[4*k +: 4] = 4'((v / p10(k)) % 10);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic l, input logic [15:0] d, input logic e, input logic u);
        load = l;
        din  = d;
        en   = e;
        up   = u;
        @(negedge clk);
    endtask

    // Model: the count is a plain integer 0..9999, the scan position follows from cycles since reset.
    always @(posedge clk or negedge rst_syn) begin : model
        int idx;
        int v;
        if (!rst_syn) begin
            m_val = 0; m_t = 0; m_carry = 1'b0; m_seg = 8'hFF; m_an = 4'hF;
        end else begin
            idx   = (m_t / SD) % D;
            m_seg = {~dp[idx], (idx > 0 && m_val / p10(idx) == 0) ? 7'h7F : SEGT[(m_val / p10(idx)) % 10]};
            m_an  = ~(4'b0001 << idx);
            m_t++;
            m_carry = 1'b0;
            if (load) begin
                v = 0;
                for (int k = 0; k < D; k++) v += ((din[4*k +: 4] > 9) ? 0 : int'(din[4*k +: 4])) * p10(k);
                m_val = v;
            end else if (en) begin
                m_carry = up ? (m_val == 9999) : (m_val == 0);
                m_val   = up ? (m_val + 1) % 10000 : (m_val + 9999) % 10000;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_syn) begin
            chk("m_count", count, to_bcd(m_val));
            chk("m_carry", carry, m_carry);
            chk("m_seg", seg, m_seg);
            chk("m_an", an, m_an);
        end
    end

    initial begin
        int nc;
        logic [7:0] xs [7];
        logic [3:0] xa [7];
        xs = '{8'hA4, 8'h19, 8'h19, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        xa = '{4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};
        repeat (2) @(negedge clk);
        chk("rst_count", count, 16'h0000);
        chk("rst_carry", carry, 1'b0);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_an", an, 4'hF);
        rst_syn = 1'b1;
        nc = 0;
        for (int k = 0; k < 10000; k++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1);
            if (carry) nc++;
            if (k == 9998) chk("up_9999", count, 16'h9999);
        end
        chk("wrap_count", count, 16'h0000);
        chk("wrap_carry", carry, 1'b1);
        chk("carry_pulses", nc, 1);
        cyc(1'b1, 16'h0990, 1'b0, 1'b1);
        chk("load_0990", count, 16'h0990);
        repeat (9) cyc(1'b0, 16'h0, 1'b1, 1'b1);
        chk("ripple_0999", count, 16'h0999);
        cyc(1'b0, 16'h0, 1'b1, 1'b1);
        chk("ripple_1000", count, 16'h1000);
        chk("ripple_nocarry", carry, 1'b0);
        cyc(1'b1, 16'h0F12, 1'b0, 1'b1);
        chk("coerce_0012", count, 16'h0012);
        cyc(1'b1, 16'h0000, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("down_9999", count, 16'h9999);
        chk("down_carry", carry, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("down_9998", count, 16'h9998);
        chk("down_carry_off", carry, 1'b0);
        cyc(1'b1, 16'h1234, 1'b1, 1'b1);
        chk("load_over_en", count, 16'h1234);
        chk("load_nocarry", carry, 1'b0);
        rst_syn = 1'b0;
        dp = 4'b0010;
        @(negedge clk);
        rst_syn = 1'b1;
        cyc(1'b1, 16'h0042, 1'b0, 1'b1);
        chk("scan_seg0", seg, 8'hC0);
        chk("scan_an0", an, 4'hE);
        for (int k = 0; k < 7; k++) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b1);
            chk("scan_seg", seg, xs[k]);
            chk("scan_an", an, xa[k]);
        end
        repeat (4) cyc(1'b0, 16'h0, 1'b0, 1'b1);
        #2 rst_syn = 1'b0;
        #1;
        chk("async_seg", seg, 8'hFF);
        chk("async_an", an, 4'hF);
        chk("async_count", count, 16'h0000);
        @(negedge clk);
        rst_syn = 1'b1;
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("restart_an", an, 4'hE);
        chk("restart_seg", seg, 8'hC0);
        repeat (2) cyc(1'b0, 16'h0, 1'b0, 1'b1);
        chk("blank_dp_an", an, 4'hD);
        chk("blank_dp_seg", seg, 8'h7F);
        for (int k = 0; k < 3000; k++) begin
            load = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 4))
                0:       din = 16'h9999;
                1:       din = 16'h0000;
                2:       din = 16'h9990;
                default: din = 16'($urandom);
            endcase
            en = ($urandom_range(0, 3) != 0);
            up = ($urandom_range(0, 5) != 0) ? up : ~up;
            dp = 4'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_syn = 1'b0;
                #1 chk("rand_rst_count", count, 16'h0000);
                rst_syn = 1'b1;
            end
            @(negedge clk);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
